// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol modes, fixed control/guard-band code words,
// the TERC4 data-island table and a popcount helper.
package tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGB    = 3'd2,
    MODE_ISLAND = 3'd3,
    MODE_DGB    = 3'd4
  } mode_t;

  // Indexed by the 2-bit control value {c1, c0}.
  localparam logic [9:0] CTRL_SYM [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] VGB_SYM [3] = '{
    10'b1011001100, 10'b0100110011, 10'b1011001100
  };

  // Set 0 carries hsync/vsync through TERC4; its entry is the sync=00 word.
  localparam logic [9:0] DGB_SYM [3] = '{
    10'b1010001110, 10'b0100110011, 10'b0100110011
  };

  localparam logic [9:0] TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, v[i]};
    return cnt;
  endfunction

endpackage

// File: rtl/tmds_encoder_hdmi_if.sv
// Pixel-side bus of the TMDS encoder. Streaming, no handshake: every clk_pix
// cycle one set of inputs is accepted and tmds shows the symbols of the inputs
// accepted two cycles earlier.
interface tmds_encoder_hdmi_if #(
  parameter int CHANNELS = 3
);
  logic [2:0]            mode;
  logic [8*CHANNELS-1:0] data_in;
  logic [2*CHANNELS-1:0] ctrl_in;
  logic [4*CHANNELS-1:0] aux_in;
  logic [10*CHANNELS-1:0] tmds;

  modport master (output mode, output data_in, output ctrl_in, output aux_in, input tmds);
  modport slave  (input mode, input data_in, input ctrl_in, input aux_in, output tmds);
endinterface

// File: rtl/tmds_channel.sv
// One TMDS channel: stage 1 builds q_m and its balance, stage 2 picks the
// output word and tracks running disparity. TERC4 paths exist only with TMDS_TERC4_EN.
module tmds_channel
  import tmds_pkg::*;
#(
  parameter int unsigned GB_SET = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] mode_i,
  input  logic [7:0] data_i,
  input  logic [1:0] ctrl_i,
`ifdef TMDS_TERC4_EN
  input  logic [3:0] aux_i,
`endif
  output logic [9:0] tmds_o
);

  localparam logic [1:0] SET = 2'(GB_SET);

  mode_t       mode_d, mode_q;
  logic [1:0]  ctrl_q;
  logic [8:0]  q_m_d, q_m_q;
  logic [4:0]  balance_d, balance_q;
  logic [4:0]  bias_d, bias_q;
  logic [9:0]  tmds_d, tmds_q;
`ifdef TMDS_TERC4_EN
  logic [3:0]  aux_q;
`endif

  // Stage 1: minimise transitions, then measure the word's DC content.
  always_comb begin
    logic [3:0] n_data;
    logic       use_xnor;
    logic [8:0] qm;
    n_data   = ones8(data_i);
    use_xnor = (n_data > 4'd4) || ((n_data == 4'd4) && !data_i[0]);
    qm       = '0;
    qm[0]    = data_i[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ data_i[i]) : (qm[i-1] ^ data_i[i]);
    qm[8]     = ~use_xnor;
    q_m_d     = qm;
    balance_d = {ones8(qm[7:0]), 1'b0} - 5'd8;
    mode_d    = (mode_i > 3'd4) ? MODE_CTRL : mode_t'(mode_i);
  end

  // Stage 2: output selection; disparity only survives across back-to-back VIDEO.
  always_comb begin
    tmds_d = CTRL_SYM[ctrl_q];
    bias_d = '0;
    case (mode_q)
      MODE_VIDEO: begin
        if ((bias_q == '0) || (balance_q == '0)) begin
          if (q_m_q[8]) begin
            tmds_d = {2'b01, q_m_q[7:0]};
            bias_d = bias_q + balance_q;
          end else begin
            tmds_d = {2'b10, ~q_m_q[7:0]};
            bias_d = bias_q - balance_q;
          end
        end else if (bias_q[4] == balance_q[4]) begin
          tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
          bias_d = bias_q + {3'b000, q_m_q[8], 1'b0} - balance_q;
        end else begin
          tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
          bias_d = bias_q + balance_q - {3'b000, ~q_m_q[8], 1'b0};
        end
      end
      MODE_VGB: tmds_d = VGB_SYM[SET];
`ifdef TMDS_TERC4_EN
      MODE_ISLAND: tmds_d = TERC4[aux_q];
      MODE_DGB:    tmds_d = (SET == 2'd0) ? TERC4[{2'b11, ctrl_q}] : DGB_SYM[SET];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q    <= MODE_CTRL;
      ctrl_q    <= 2'b00;
      q_m_q     <= '0;
      balance_q <= '0;
      bias_q    <= '0;
      tmds_q    <= CTRL_SYM[0];
`ifdef TMDS_TERC4_EN
      aux_q     <= '0;
`endif
    end else begin
      mode_q    <= mode_d;
      ctrl_q    <= ctrl_i;
      q_m_q     <= q_m_d;
      balance_q <= balance_d;
      bias_q    <= bias_d;
      tmds_q    <= tmds_d;
`ifdef TMDS_TERC4_EN
      aux_q     <= aux_i;
`endif
    end
  end

  assign tmds_o = tmds_q;

endmodule

// File: rtl/tmds_encoder_hdmi.sv
// Multi-channel HDMI TMDS encoder; channel i uses guard-band set i % 3.
// Define TMDS_TERC4_EN for data-island support; without it the build is DVI-only.
module tmds_encoder_hdmi #(
  parameter int CHANNELS = 3
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  tmds_encoder_hdmi_if.slave bus
);

  logic [10*CHANNELS-1:0] tmds_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tmds_channel #(
      .GB_SET(i % 3)
    ) u_ch (
      .clk_i  (clk_pix),
      .rst_i  (rst_pix),
      .mode_i (bus.mode),
      .data_i (bus.data_in[8*i +: 8]),
      .ctrl_i (bus.ctrl_in[2*i +: 2]),
`ifdef TMDS_TERC4_EN
      .aux_i  (bus.aux_in[4*i +: 4]),
`endif
      .tmds_o (tmds_w[10*i +: 10])
    );
  end

`ifndef TMDS_TERC4_EN
  // aux_in has no consumer in the DVI-only build.
  logic unused_aux;
  assign unused_aux = ^bus.aux_in;
`endif

  assign bus.tmds = tmds_w;

endmodule

// File: tb/tb_tmds_encoder_hdmi.sv
// Bench for tmds_encoder_hdmi: vector table through a 2-deep expected queue,
// plus reset sequences and randomised control-period symbols.
module tb_tmds_encoder_hdmi;

  localparam logic [9:0] C00  = 10'b1101010100;
  localparam logic [9:0] C01  = 10'b0010101011;
  localparam logic [9:0] C10  = 10'b0101010100;
  localparam logic [9:0] C11  = 10'b1010101011;
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;
  localparam logic [29:0] ALL_C00 = {C00, C00, C00};

  logic clk_pix = 1'b0;
  logic rst_pix;
  int   total = 0;
  int   bad   = 0;

  logic [29:0] exp_q[$];
  logic [29:0] msk_q[$];
  string       tag_q[$];

  typedef struct {
    logic [2:0]  mode;
    logic [23:0] data;
    logic [5:0]  ctrl;
    logic [11:0] aux;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs [22];
  logic [9:0] ctrl_tb [4];

  tmds_encoder_hdmi_if #(.CHANNELS(3)) bus ();

  tmds_encoder_hdmi #(.CHANNELS(3)) dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .bus     (bus)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input logic [29:0] e, input logic [29:0] k, input string tag);
    total++;
    if (((bus.tmds ^ e) & k) != '0) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, bus.tmds, e);
    end
  endtask

  // Drive one input set, then compare the output due from two steps earlier.
  task automatic step(input logic [2:0] m, input logic [23:0] d, input logic [5:0] c,
                      input logic [11:0] a, input logic [29:0] e, input logic [29:0] k,
                      input string tag);
    logic [29:0] ee, kk;
    string tt;
    bus.mode    = m;
    bus.data_in = d;
    bus.ctrl_in = c;
    bus.aux_in  = a;
    exp_q.push_back(e);
    msk_q.push_back(k);
    tag_q.push_back(tag);
    @(negedge clk_pix);
    if (exp_q.size() == 2) begin
      ee = exp_q.pop_front();
      kk = msk_q.pop_front();
      tt = tag_q.pop_front();
      if (kk != '0) check(ee, kk, tt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'd0, 24'h0, 6'h0, 12'h0, '0, '0, "idle");
  endtask

  // Two reset edges with live VIDEO input; returns at the negedge after release.
  task automatic do_reset(input string tag);
    rst_pix     = 1'b1;
    bus.mode    = 3'd1;
    bus.data_in = 24'($urandom);
    bus.ctrl_in = 6'($urandom);
    bus.aux_in  = 12'($urandom);
    exp_q.delete();
    msk_q.delete();
    tag_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_pix);
      check(ALL_C00, '1, tag);
    end
    rst_pix = 1'b0;
  endtask

  initial begin
    ctrl_tb = '{C00, C01, C10, C11};

    vecs[0]  = '{3'd1, 24'h000000, 6'h00, 12'h000, {3{10'b0100000000}}};
    vecs[1]  = '{3'd1, 24'h000000, 6'h00, 12'h000, {3{10'b1111111111}}};
    vecs[2]  = '{3'd1, 24'h000000, 6'h00, 12'h000, {3{10'b0100000000}}};
    vecs[3]  = '{3'd0, 24'h123456, 6'b111001, 12'h000, {C11, C10, C01}};
    vecs[4]  = '{3'd1, 24'h000000, 6'h00, 12'h000, {3{10'b0100000000}}};
    vecs[5]  = '{3'd2, 24'h000000, 6'h00, 12'h000, {GB_A, GB_B, GB_A}};
`ifdef TMDS_TERC4_EN
    vecs[6]  = '{3'd4, 24'h000000, 6'b000000, 12'h000, {GB_B, GB_B, 10'b1010001110}};
    vecs[7]  = '{3'd4, 24'h000000, 6'b000011, 12'h000, {GB_B, GB_B, 10'b1011000011}};
    vecs[8]  = '{3'd3, 24'h000000, 6'h00, 12'h000, {3{10'b1010011100}}};
    vecs[9]  = '{3'd3, 24'h000000, 6'h00, 12'hFFF, {3{10'b1011000011}}};
    vecs[10] = '{3'd3, 24'h000000, 6'h00, 12'hCF0, {10'b1010001110, 10'b1011000011, 10'b1010011100}};
`else
    vecs[6]  = '{3'd4, 24'h000000, 6'b000000, 12'h000, ALL_C00};
    vecs[7]  = '{3'd4, 24'h000000, 6'b000011, 12'h000, {C00, C00, C11}};
    vecs[8]  = '{3'd3, 24'h000000, 6'h00, 12'h000, ALL_C00};
    vecs[9]  = '{3'd3, 24'h000000, 6'h00, 12'hFFF, ALL_C00};
    vecs[10] = '{3'd3, 24'h000000, 6'h00, 12'hCF0, ALL_C00};
`endif
    vecs[11] = '{3'd5, 24'h000000, 6'b010101, 12'h000, {3{C01}}};
    vecs[12] = '{3'd7, 24'h000000, 6'b111111, 12'hABC, {3{C11}}};
    vecs[13] = '{3'd1, 24'hFFFFFF, 6'h00, 12'h000, {3{10'b1000000000}}};
    vecs[14] = '{3'd1, 24'hFFFFFF, 6'h00, 12'h000, {3{10'b0011111111}}};
    vecs[15] = '{3'd1, 24'h555555, 6'h00, 12'h000, {3{10'b0100110011}}};
    vecs[16] = '{3'd1, 24'h101010, 6'h00, 12'h000, {3{10'b0111110000}}};
    vecs[17] = '{3'd1, 24'h010101, 6'h00, 12'h000, {3{10'b0111111111}}};
    vecs[18] = '{3'd1, 24'h010101, 6'h00, 12'h000, {3{10'b1100000000}}};
    vecs[19] = '{3'd1, 24'h0F0F0F, 6'h00, 12'h000, {3{10'b0100000101}}};
    vecs[20] = '{3'd1, 24'hF0F0F0, 6'h00, 12'h000, {3{10'b0011111010}}};
    vecs[21] = '{3'd6, 24'hF0F0F0, 6'b100100, 12'h000, {C10, C01, C00}};

    // Reset with VIDEO on the inputs; output idles until two cycles after release.
    do_reset("reset_hold");
    step(vecs[0].mode, vecs[0].data, vecs[0].ctrl, vecs[0].aux, vecs[0].exp, '1, "vec0");
    check(ALL_C00, '1, "post_release");
    for (int i = 1; i < 22; i++)
      step(vecs[i].mode, vecs[i].data, vecs[i].ctrl, vecs[i].aux, vecs[i].exp, '1,
           $sformatf("vec%0d", i));
    idle(2);

    // Randomised control period, including the 5-7 mode aliases.
    for (int n = 0; n < 20; n++) begin
      int r;
      logic [2:0] m;
      logic [5:0] c;
      r = $urandom_range(0, 3);
      m = (r == 0) ? 3'd0 : 3'(4 + r);
      c = 6'($urandom_range(0, 63));
      step(m, 24'($urandom), c, 12'($urandom),
           {ctrl_tb[c[5:4]], ctrl_tb[c[3:2]], ctrl_tb[c[1:0]]}, '1,
           $sformatf("rand_ctrl%0d", n));
    end
    idle(2);

    // Reset in the middle of a VIDEO run: in-flight symbols are dropped.
    step(3'd1, 24'hFFFFFF, 6'h0, 12'h0, '0, '0, "inflight0");
    step(3'd1, 24'h0F0F0F, 6'h0, 12'h0, '0, '0, "inflight1");
    do_reset("midreset_hold");
    step(3'd1, 24'h000000, 6'h0, 12'h0, {3{10'b0100000000}}, '1, "midreset_v0");
    check(ALL_C00, '1, "midreset_post_release");
    step(3'd1, 24'h000000, 6'h0, 12'h0, {3{10'b1111111111}}, '1, "midreset_v1");
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
